// File: rtl/sha256_msg_padder.sv
// Byte-stream SHA-256 padder: builds padded 512-bit blocks, drives the core block handshake, captures the digest.
// Define SHA256_PAD_EMPTY_EN to add s_empty for zero-length messages.
module sha256_msg_padder #(
    parameter int LEN_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   s_data,
    input  logic         s_valid,
    input  logic         s_last,
`ifdef SHA256_PAD_EMPTY_EN
    input  logic         s_empty,
`endif
    output logic         s_ready,
    output logic [511:0] core_block,
    output logic         core_first_run,
    output logic         core_start,
    input  logic         core_ready,
    input  logic [255:0] core_hash,
    output logic [255:0] digest,
    output logic         digest_valid,
    output logic         busy
);
    typedef enum logic [2:0] {S_FILL, S_RUN, S_WAIT, S_GAP, S_PAD, S_FIN} state_t;
    typedef enum logic [1:0] {N_NONE, N_DIGEST, N_LENBLK, N_PADBLK} nxt_t;

    state_t           r_state, w_state_nx;
    nxt_t             r_nxt, w_nxt_nx;
    logic             r_phase, w_phase_nx;
    logic [5:0]       r_cnt;
    logic [LEN_W-1:0] r_len;
    logic [511:0]     r_buf;
    logic             r_first;
    logic             r_busy;
    logic             r_dv;
    logic [255:0]     r_digest;

    logic             w_acc;
    logic             w_empty;
    logic [6:0]       w_q;
    logic [LEN_W-1:0] w_len_nx;
    logic [63:0]      w_bitlen_fill;
    logic [63:0]      w_bitlen_pad;
    logic [511:0]     w_buf_fill;
    logic [511:0]     w_buf_pad;

    assign w_acc    = (r_state == S_FILL) && s_valid;
    assign w_q      = {1'b0, r_cnt} + 7'd1;
    assign w_len_nx = r_len + 1'b1;
`ifdef SHA256_PAD_EMPTY_EN
    assign w_empty  = s_empty && r_first && (r_cnt == 6'd0);
`else
    assign w_empty  = 1'b0;
`endif

    assign w_bitlen_fill = 64'({w_len_nx, 3'b000});
    assign w_bitlen_pad  = 64'({r_len, 3'b000});

    // Block image after the current byte lands, including 0x80 and length when they fit.
    always_comb begin
        w_buf_fill = r_buf;
        if (w_empty) begin
            w_buf_fill[511:504] = 8'h80;
        end else begin
            w_buf_fill[511-8*int'(r_cnt) -: 8] = s_data;
            if (s_last && (w_q <= 7'd63))
                w_buf_fill[511-8*int'(w_q[5:0]) -: 8] = 8'h80;
            if (s_last && (w_q <= 7'd55))
                w_buf_fill[63:0] = w_bitlen_fill;
        end
    end

    always_comb begin
        w_buf_pad       = '0;
        w_buf_pad[63:0] = w_bitlen_pad;
        if (r_nxt == N_PADBLK)
            w_buf_pad[511:504] = 8'h80;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FILL;
            r_nxt   <= N_NONE;
            r_phase <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_nxt   <= w_nxt_nx;
            r_phase <= w_phase_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_nxt_nx   = r_nxt;
        w_phase_nx = 1'b0;
        s_ready    = 1'b0;
        core_start = 1'b0;
        case (r_state)
            S_FILL: begin
                s_ready = 1'b1;
                if (w_acc) begin
                    if (w_empty) begin
                        w_state_nx = S_RUN;
                        w_nxt_nx   = N_DIGEST;
                    end else if (s_last) begin
                        w_state_nx = S_RUN;
                        if (w_q <= 7'd55)      w_nxt_nx = N_DIGEST;
                        else if (w_q <= 7'd63) w_nxt_nx = N_LENBLK;
                        else                   w_nxt_nx = N_PADBLK;
                    end else if (w_q == 7'd64) begin
                        w_state_nx = S_RUN;
                        w_nxt_nx   = N_NONE;
                    end
                end
            end
            // Two blind start cycles: core_ready is stale until the core reacts.
            S_RUN: begin
                core_start = 1'b1;
                w_phase_nx = ~r_phase;
                if (r_phase) w_state_nx = S_WAIT;
            end
            S_WAIT: begin
                core_start = 1'b1;
                if (core_ready) w_state_nx = S_GAP;
            end
            S_GAP: begin
                w_phase_nx = ~r_phase;
                if (r_phase) begin
                    case (r_nxt)
                        N_NONE:   w_state_nx = S_FILL;
                        N_DIGEST: w_state_nx = S_FIN;
                        default:  w_state_nx = S_PAD;
                    endcase
                end
            end
            S_PAD: begin
                w_nxt_nx   = N_DIGEST;
                w_state_nx = S_RUN;
            end
            S_FIN:   w_state_nx = S_FILL;
            default: w_state_nx = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_len    <= '0;
            r_buf    <= '0;
            r_first  <= 1'b1;
            r_busy   <= 1'b0;
            r_dv     <= 1'b0;
            r_digest <= '0;
        end else begin
            r_dv <= 1'b0;
            case (r_state)
                S_FILL: if (w_acc) begin
                    r_busy <= 1'b1;
                    r_buf  <= w_buf_fill;
                    if (!w_empty) begin
                        r_cnt <= r_cnt + 6'd1;
                        r_len <= w_len_nx;
                    end
                end
                S_WAIT: if (core_ready) begin
                    r_first <= 1'b0;
                    if (r_nxt == N_DIGEST) begin
                        r_digest <= core_hash;
                        r_dv     <= 1'b1;
                        r_busy   <= 1'b0;
                    end
                end
                S_GAP: begin
                    r_buf <= '0;
                    r_cnt <= '0;
                end
                S_PAD: r_buf <= w_buf_pad;
                S_FIN: begin
                    r_first <= 1'b1;
                    r_len   <= '0;
                end
                default: ;
            endcase
        end
    end

    assign core_block     = r_buf;
    assign core_first_run = r_first;
    assign digest         = r_digest;
    assign digest_valid   = r_dv;
    assign busy           = r_busy;
endmodule
